// File: rtl/color_sensor_emulator_if.sv
`default_nettype none
// ============================================================================
// Module      : color_sensor_emulator_if
// Description : Pin-level bundle between a colour-sensing controller and the
//               emulated TCS3200-style light-to-frequency sensor.
//               master : controller side (drives s0..s3, oe_n, cfg_*)
//               slave  : sensor side (drives colorsignal, active)
// Signals     : s0,s1           frequency scaling (00 off, 01 2%, 10 20%, 11 100%)
//               s2,s3           filter select (00 red, 01 blue, 10 clear, 11 green)
//               oe_n            output enable, active-low
//               cfg_we          single-cycle half-period write strobe
//               cfg_sel         register index, encoded as {s2,s3}
//               cfg_half_period half-period value at 100% scale
//               colorsignal     square-wave output
//               active          high while the wave generator is running
// Revision    : 1.0 - initial release
// ============================================================================
interface color_sensor_emulator_if #(
    parameter int CNT_W = 20
);
    logic             s0;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             oe_n;
    logic             cfg_we;
    logic [1:0]       cfg_sel;
    logic [CNT_W-1:0] cfg_half_period;
    logic             colorsignal;
    logic             active;

    modport master (
        output s0, s1, s2, s3, oe_n, cfg_we, cfg_sel, cfg_half_period,
        input  colorsignal, active
    );

    modport slave (
        input  s0, s1, s2, s3, oe_n, cfg_we, cfg_sel, cfg_half_period,
        output colorsignal, active
    );
endinterface
`default_nettype wire

// File: rtl/color_sensor_emulator.sv
`default_nettype none
// ============================================================================
// Module      : color_sensor_emulator
// Description : Synthesizable stand-in for a TCS3200-style light-to-frequency
//               sensor. Produces a 50%-duty square wave whose half-period is
//               a per-filter programmable register multiplied by the scale
//               selected on s0/s1. Output is held low for SETTLE_CYCLES after
//               any pin change.
// Ports       : clock    100 MHz system clock, rising edge
//               reset_n  asynchronous active-low reset
//               bus      color_sensor_emulator_if.slave (pins, cfg, outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module color_sensor_emulator #(
    parameter int CNT_W         = 20,
    parameter int SETTLE_CYCLES = 100
) (
    input  wire                       clock,
    input  wire                       reset_n,
    color_sensor_emulator_if.slave    bus
);

    localparam int c_HW = CNT_W + 6;  // wide enough for reg * 50
    localparam int c_SW = 16;         // settle counter covers 1..2^16-1

    localparam logic [CNT_W-1:0] c_DEF_RED   = CNT_W'(2500);
    localparam logic [CNT_W-1:0] c_DEF_BLUE  = CNT_W'(3000);
    localparam logic [CNT_W-1:0] c_DEF_CLEAR = CNT_W'(1000);
    localparam logic [CNT_W-1:0] c_DEF_GREEN = CNT_W'(3500);
    localparam logic [c_SW-1:0]  c_SETTLE_LAST = c_SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t           r_state;
    logic [3:0]       r_sel_q;     // {s0,s1,s2,s3} sampled
    logic [3:0]       r_sel_prev;  // previous r_sel_q, for change detection
    logic [CNT_W-1:0] r_half [4];
    logic [c_SW-1:0]  r_settle_cnt;
    logic [c_HW-1:0]  r_phase;
    logic [c_HW-1:0]  r_h;         // half-period latched at entry / toggle
    logic             r_wave;
    logic             r_active;

    logic             w_change;
    logic [5:0]       w_scale;
    logic [c_HW-1:0]  w_h;

    assign w_change = (r_sel_q != r_sel_prev);

    always_comb begin
        w_scale = 6'd0;
        case (r_sel_q[3:2])
            2'b11:   w_scale = 6'd1;
            2'b10:   w_scale = 6'd5;
            2'b01:   w_scale = 6'd50;
            default: w_scale = 6'd0;
        endcase
    end

    assign w_h = c_HW'(r_half[r_sel_q[1:0]]) * c_HW'(w_scale);

    // oe_n masks only the output; the internal wave keeps its phase.
    assign bus.colorsignal = r_wave & ~bus.oe_n;
    assign bus.active      = r_active;

    // Half-period registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_half[0] <= c_DEF_RED;
            r_half[1] <= c_DEF_BLUE;
            r_half[2] <= c_DEF_CLEAR;
            r_half[3] <= c_DEF_GREEN;
        end else if (bus.cfg_we) begin
            r_half[bus.cfg_sel] <= bus.cfg_half_period;
        end
    end

    // Pin sampling
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sel_q    <= 4'b0000;
            r_sel_prev <= 4'b0000;
        end else begin
            r_sel_q    <= {bus.s0, bus.s1, bus.s2, bus.s3};
            r_sel_prev <= r_sel_q;
        end
    end

    // Main FSM with registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_OFF;
            r_settle_cnt <= '0;
            r_phase      <= '0;
            r_h          <= '0;
            r_wave       <= 1'b0;
            r_active     <= 1'b0;
        end else if (w_change) begin
            // Any change restarts settling, or powers down when scaling is 00.
            r_state      <= (r_sel_q[3:2] == 2'b00) ? ST_OFF : ST_SETTLE;
            r_settle_cnt <= '0;
            r_phase      <= '0;
            r_h          <= '0;
            r_wave       <= 1'b0;
            r_active     <= 1'b0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    r_settle_cnt <= '0;
                    r_phase      <= '0;
                    r_h          <= '0;
                    r_wave       <= 1'b0;
                    r_active     <= 1'b0;
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == c_SETTLE_LAST) begin
                        r_state      <= ST_RUN;
                        r_active     <= 1'b1;
                        r_settle_cnt <= '0;
                        r_phase      <= '0;
                        r_h          <= w_h;
                        r_wave       <= (w_h != '0);
                    end else begin
                        r_settle_cnt <= r_settle_cnt + c_SW'(1);
                    end
                end
                ST_RUN: begin
                    if (r_h == '0) begin
                        // Parked with a zero half-period: re-evaluate each cycle.
                        r_h     <= w_h;
                        r_phase <= '0;
                        r_wave  <= (w_h != '0);
                    end else if (r_phase == r_h - c_HW'(1)) begin
                        // Toggle and pick up any register write made meanwhile.
                        r_phase <= '0;
                        r_h     <= w_h;
                        r_wave  <= (w_h == '0) ? 1'b0 : ~r_wave;
                    end else begin
                        r_phase <= r_phase + c_HW'(1);
                    end
                end
                default: begin
                    r_state <= ST_OFF;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_color_sensor_emulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_color_sensor_emulator
// Description : Self-checking bench for color_sensor_emulator. A behavioural
//               model (countdown of remaining cycles per phase) runs alongside
//               the DUT; directed wave measurements plus randomized pin,
//               register and oe_n traffic are compared against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_color_sensor_emulator;

    localparam int CNT_W  = 20;
    localparam int SETTLE = 100;

    localparam int M_OFF    = 0;
    localparam int M_SETTLE = 1;
    localparam int M_RUN    = 2;

    logic clock = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   sb_on = 1'b0;

    color_sensor_emulator_if #(.CNT_W(CNT_W)) bus ();

    color_sensor_emulator #(
        .CNT_W         (CNT_W),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // ---------------------------------------------------------------- checker
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    longint   m_regs [4];
    int       m_mode;
    logic [3:0] m_sel_q, m_sel_prev;
    longint   m_left, m_h;
    logic     m_level;

    function automatic longint h_of(input logic [3:0] sel);
        longint sc;
        case (sel[3:2])
            2'b11:   sc = 1;
            2'b10:   sc = 5;
            2'b01:   sc = 50;
            default: sc = 0;
        endcase
        return m_regs[sel[1:0]] * sc;
    endfunction

    task automatic model_reset();
        m_regs[0] = 2500; m_regs[1] = 3000; m_regs[2] = 1000; m_regs[3] = 3500;
        m_mode = M_OFF; m_sel_q = 4'b0; m_sel_prev = 4'b0;
        m_left = 0; m_h = 0; m_level = 1'b0;
    endtask

    task automatic model_step();
        bit     chg;
        longint hn;
        chg = (m_sel_q != m_sel_prev);
        hn  = h_of(m_sel_q);
        if (chg) begin
            m_level = 1'b0;
            if (m_sel_q[3:2] == 2'b00) m_mode = M_OFF;
            else begin m_mode = M_SETTLE; m_left = SETTLE; end
        end else if (m_mode == M_SETTLE) begin
            m_left--;
            if (m_left == 0) begin
                m_mode = M_RUN; m_h = hn; m_left = hn; m_level = (hn != 0);
            end
        end else if (m_mode == M_RUN) begin
            if (m_h == 0) begin
                m_h = hn; m_left = hn; m_level = (hn != 0);
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_level = (hn == 0) ? 1'b0 : !m_level;
                    m_h = hn; m_left = hn;
                end
            end
        end
        if (bus.cfg_we === 1'b1) m_regs[bus.cfg_sel] = longint'(bus.cfg_half_period);
        m_sel_prev = m_sel_q;
        m_sel_q    = {bus.s0, bus.s1, bus.s2, bus.s3};
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) model_reset();
            else          model_step();
        end
    end

    // Cycle-by-cycle scoreboard
    initial begin
        forever begin
            @(negedge clock);
            if (sb_on) begin
                check_eq("sb_colorsignal", 32'(bus.colorsignal), 32'(m_level & ~bus.oe_n));
                check_eq("sb_active", 32'(bus.active), 32'(m_mode == M_RUN));
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic set_pins(input logic [3:0] p);
        {bus.s0, bus.s1, bus.s2, bus.s3} = p;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input int val);
        bus.cfg_we = 1'b1;
        bus.cfg_sel = sel;
        bus.cfg_half_period = CNT_W'(val);
        cyc(1);
        bus.cfg_we = 1'b0;
    endtask

    // Cycles until colorsignal reaches lvl (returns limit on timeout).
    task automatic wait_lvl(input logic lvl, input int limit, output int n);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (bus.colorsignal !== lvl && n < limit);
    endtask

    // ---------------------------------------------------------------- watchdog
    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "timeout");
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        int n;
        reset_n = 1'b0;
        set_pins(4'b1100);
        bus.oe_n = 1'b0;
        bus.cfg_we = 1'b0;
        bus.cfg_sel = 2'b00;
        bus.cfg_half_period = '0;
        @(negedge clock);
        #1;
        cyc(3);
        check_eq("reset_colorsignal", 32'(bus.colorsignal), 0);
        check_eq("reset_active", 32'(bus.active), 0);
        sb_on = 1'b1;

        // Red, 100%
        reset_n = 1'b1;
        wait_lvl(1'b1, 200, n);   check_eq("first_rise", n, 102);
        check_eq("run_active", 32'(bus.active), 1);
        wait_lvl(1'b0, 3000, n);  check_eq("red_high", n, 2500);
        wait_lvl(1'b1, 3000, n);  check_eq("red_low", n, 2500);

        // Green, 100% then 20%
        set_pins(4'b1111);
        cyc(2);                   check_eq("green_settle_low", 32'(bus.colorsignal), 0);
        wait_lvl(1'b1, 200, n);   check_eq("green_settle", n, 100);
        wait_lvl(1'b0, 4000, n);  check_eq("green_half", n, 3500);
        set_pins(4'b1011);
        cyc(2);
        wait_lvl(1'b1, 200, n);   check_eq("x5_settle", n, 100);
        wait_lvl(1'b0, 18000, n); check_eq("green_x5_half", n, 17500);

        // Blue at 2%: 21000*50 exceeds 2^20, so a truncated product would toggle early
        cfg_write(2'b01, 21000);
        set_pins(4'b0101);
        cyc(2);
        wait_lvl(1'b1, 200, n);   check_eq("blue_settle", n, 100);
        cyc(3000);                check_eq("blue_x50_wide", 32'(bus.colorsignal), 1);

        // Power down
        set_pins(4'b0001);
        cyc(1);                   check_eq("off_sample_active", 32'(bus.active), 1);
        cyc(1);
        check_eq("off_colorsignal", 32'(bus.colorsignal), 0);
        check_eq("off_active", 32'(bus.active), 0);

        // Zero half-period handling
        cfg_write(2'b00, 40);
        set_pins(4'b1100);
        wait_lvl(1'b1, 200, n);   check_eq("red40_rise", n, 102);
        wait_lvl(1'b0, 100, n);   check_eq("red40_high", n, 40);
        cfg_write(2'b00, 0);
        cyc(200);
        check_eq("red0_hold", 32'(bus.colorsignal), 0);
        check_eq("red0_active", 32'(bus.active), 1);
        cfg_write(2'b00, 10);
        wait_lvl(1'b1, 5, n);     check_eq("red10_rise", n, 1);
        wait_lvl(1'b0, 30, n);    check_eq("red10_half", n, 10);

        // Output enable masking
        cfg_write(2'b00, 400);
        cyc(50);
        bus.oe_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(500);
            check_eq("oe_mask", 32'(bus.colorsignal), 0);
        end
        bus.oe_n = 1'b0;
        #1;
        check_eq("oe_resume", 32'(bus.colorsignal), 32'(m_level));

        // Reset mid-RUN restores register defaults
        set_pins(4'b1111);
        cfg_write(2'b11, 777);
        cyc(300);
        reset_n = 1'b0;
        #1;
        check_eq("rst_colorsignal", 32'(bus.colorsignal), 0);
        check_eq("rst_active", 32'(bus.active), 0);
        cyc(1);
        reset_n = 1'b1;
        wait_lvl(1'b1, 200, n);   check_eq("rst_rise", n, 102);
        wait_lvl(1'b0, 4000, n);  check_eq("green_default", n, 3500);

        // Settle window restarts from the last change
        set_pins(4'b1101);
        cyc(30);
        set_pins(4'b1111);
        cyc(30);
        set_pins(4'b1101);
        wait_lvl(1'b1, 200, n);   check_eq("settle_restart", n, 102);

        // Randomized traffic, checked by the scoreboard
        for (int it = 0; it < 60; it++) begin
            logic [1:0] sc;
            sc = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) begin
                bus.cfg_we = 1'b1;
                bus.cfg_sel = 2'($urandom_range(0, 3));
                bus.cfg_half_period = CNT_W'($urandom_range(0, 80));
            end
            set_pins({sc, 2'($urandom_range(0, 3))});
            bus.oe_n = ($urandom_range(0, 3) == 0);
            cyc(1);
            bus.cfg_we = 1'b0;
            cyc($urandom_range(20, 400));
        end
        bus.oe_n = 1'b0;
        cyc(5);

        sb_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
